// File: rtl/fpadd_wb_if.sv
// rtl/fpadd_wb_if.sv - fpadd writeback handshake, result and flag signals
interface fpadd_wb_if #(
    parameter int TAGW = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [63:0]     result;
    logic [4:0]      Flags;
    logic            Denorm;
    logic [1:0]      P;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_data;
    logic [TAGW-1:0] out_tag;
    logic [4:0]      out_flags;
    logic            out_denorm;
    logic            fflags_we;
    logic [4:0]      fflags_wdata;
    logic [4:0]      fflags;
    logic [15:0]     retire_cnt;

    modport slave (
        input  in_valid, result, Flags, Denorm, P, in_tag, out_ready,
               fflags_we, fflags_wdata,
        output in_ready, out_valid, out_data, out_tag, out_flags, out_denorm,
               fflags, retire_cnt
    );

    modport master (
        output in_valid, result, Flags, Denorm, P, in_tag, out_ready,
               fflags_we, fflags_wdata,
        input  in_ready, out_valid, out_data, out_tag, out_flags, out_denorm,
               fflags, retire_cnt
    );
endinterface

// File: rtl/fpadd_wb.sv
// rtl/fpadd_wb.sv - fpadd writeback stage: NaN-boxing FIFO, sticky flags, retire counter
module fpadd_wb #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic      clk,
    input  logic      reset,
    fpadd_wb_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    // Entry layout: {data[63:0], tag, flags[4:0], denorm}
    localparam int EW = 64 + TAGW + 6;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [4:0]      fflags_q, fflags_d;
    logic [15:0]     rcnt_q, rcnt_d;

    logic            nonempty;
    logic            push;
    logic            pop;
    logic [63:0]     pack_data;
    logic [EW-1:0]   head;

    // Ready depends only on registered occupancy, so a full FIFO never takes a push
    // even when it is popping in the same cycle.
    assign bus.in_ready = reset && (count_q < FULL);
    assign nonempty     = (count_q != '0);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = nonempty && bus.out_ready;

    // Single-precision results arrive in the upper word; box them with all-ones.
    assign pack_data = (bus.P == 2'b01) ? {32'hFFFF_FFFF, bus.result[63:32]} : bus.result;

    // Head read is masked to zero while empty so stale entries never leak out.
    assign head           = nonempty ? mem_q[rptr_q] : '0;
    assign bus.out_valid  = nonempty;
    assign bus.out_data   = head[EW-1:TAGW+6];
    assign bus.out_tag    = head[TAGW+5:6];
    assign bus.out_flags  = head[5:1];
    assign bus.out_denorm = head[0];
    assign bus.fflags     = fflags_q;
    assign bus.retire_cnt = rcnt_q;

    // Next-state for pointers, occupancy, sticky flags and retire count.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        fflags_d = (bus.fflags_we ? bus.fflags_wdata : fflags_q)
                 | (pop ? bus.out_flags : 5'b0);
        rcnt_d   = rcnt_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
            rcnt_d = rcnt_q + 16'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards every queued entry at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            fflags_q <= '0;
            rcnt_q   <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
            rcnt_q   <= rcnt_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {pack_data, bus.in_tag, bus.Flags, bus.Denorm};
        end
    end
endmodule

// File: tb/tb_fpadd_wb.sv
// tb/tb_fpadd_wb.sv - self-checking bench for fpadd_wb against a queue model
module tb_fpadd_wb;
    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  tag;
        logic [4:0]  flags;
        logic        denorm;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fpadd_wb_if #(.TAGW(5)) bus ();
    fpadd_wb #(.DEPTH(4), .TAGW(5)) dut (.clk(clk), .reset(reset_n), .bus(bus));

    int          n_vec = 0;
    int          n_err = 0;
    ent_t        mq[$];
    logic [4:0]  m_fflags;
    logic [15:0] m_rc;

    function automatic logic [63:0] box(input logic [63:0] r, input logic [1:0] p);
        if (p == 2'b01) return {32'hFFFF_FFFF, r[63:32]};
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        ent_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        check("in_ready",   bus.in_ready,   mq.size() < 4);
        check("out_valid",  bus.out_valid,  mq.size() > 0);
        check("out_data",   bus.out_data,   h.data);
        check("out_tag",    bus.out_tag,    h.tag);
        check("out_flags",  bus.out_flags,  h.flags);
        check("out_denorm", bus.out_denorm, h.denorm);
        check("fflags",     bus.fflags,     m_fflags);
        check("retire_cnt", bus.retire_cnt, m_rc);
    endtask

    // Apply the currently driven inputs for one clock edge and advance the model.
    task automatic cycle();
        logic       push, pop;
        ent_t       e;
        logic [4:0] nf;
        push = reset_n && bus.in_valid && (mq.size() < 4);
        pop  = reset_n && bus.out_ready && (mq.size() > 0);
        e    = {box(bus.result, bus.P), bus.in_tag, bus.Flags, bus.Denorm};
        nf   = bus.fflags_we ? bus.fflags_wdata : m_fflags;
        if (pop) nf = nf | mq[0].flags;
        @(posedge clk);
        m_fflags = nf;
        if (pop) begin
            void'(mq.pop_front());
            m_rc = m_rc + 16'd1;
        end
        if (push) mq.push_back(e);
        #1;
    endtask

    task automatic drive_rand();
        bus.result = {$urandom, $urandom};
        bus.P      = 2'($urandom_range(0, 3));
        bus.in_tag = 5'($urandom);
        bus.Flags  = 5'($urandom);
        bus.Denorm = 1'($urandom);
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b0;
        bus.fflags_we    = 1'b0;
        bus.fflags_wdata = 5'b0;
        bus.result       = 64'b0;
        bus.P            = 2'b00;
        bus.in_tag       = 5'b0;
        bus.Flags        = 5'b0;
        bus.Denorm       = 1'b0;
        m_fflags         = 5'b0;
        m_rc             = 16'b0;

        // Reset state
        #1;
        check("rst_in_ready",  bus.in_ready,   1'b0);
        check("rst_out_valid", bus.out_valid,  1'b0);
        check("rst_out_data",  bus.out_data,   64'b0);
        check("rst_fflags",    bus.fflags,     5'b0);
        check("rst_retire",    bus.retire_cnt, 16'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        // Single-precision NaN-boxing
        bus.result = 64'h3F80_0000_0000_0000; bus.P = 2'b01; bus.in_tag = 5'd3;
        bus.Flags = 5'b00001; bus.Denorm = 1'b0; bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        check_all();
        check("sp_out_data", bus.out_data, 64'hFFFF_FFFF_3F80_0000);
        check("sp_out_tag",  bus.out_tag,  5'd3);
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        check_all();
        check("sp_fflags", bus.fflags,     5'b00001);
        check("sp_retire", bus.retire_cnt, 16'd1);

        // Double precision passes through untouched
        bus.result = 64'h4000_0000_0000_0000; bus.P = 2'b00; bus.in_tag = 5'd7;
        bus.Flags = 5'b0; bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        check_all();
        check("dp_out_data", bus.out_data, 64'h4000_0000_0000_0000);
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        check_all();

        // Fill and backpressure: fifth push must be refused
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            bus.in_tag = 5'(i);
            cycle();
            check_all();
        end
        bus.in_valid = 1'b0;
        check("full_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fifo_order_tag", bus.out_tag, 5'(i));
            cycle();
            check_all();
        end
        bus.out_ready = 1'b0;
        check("drained_out_valid", bus.out_valid, 1'b0);

        // Sticky flags: a popped flag survives a simultaneous software clear
        bus.fflags_we = 1'b1; bus.fflags_wdata = 5'b00100;
        cycle();
        bus.fflags_we = 1'b0;
        check("sw_write_fflags", bus.fflags, 5'b00100);
        drive_rand();
        bus.Flags = 5'b10000; bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        bus.fflags_we = 1'b1; bus.fflags_wdata = 5'b00000; bus.out_ready = 1'b1;
        cycle();
        bus.fflags_we = 1'b0; bus.out_ready = 1'b0;
        check("collide_fflags", bus.fflags, 5'b10000);
        check_all();

        // Randomized mixed traffic, exercising pointer wrap many times over
        for (int i = 0; i < 300; i++) begin
            drive_rand();
            bus.in_valid     = 1'($urandom_range(0, 1));
            bus.out_ready    = 1'($urandom_range(0, 1));
            bus.fflags_we    = ($urandom_range(0, 7) == 0);
            bus.fflags_wdata = 5'($urandom);
            cycle();
            check_all();
        end
        bus.fflags_we = 1'b0;

        // Reset mid-stream with three entries queued
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (5) cycle();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            cycle();
        end
        bus.in_valid = 1'b0;
        check("pre_reset_valid", bus.out_valid, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_in_ready",  bus.in_ready,  1'b0);
        mq.delete();
        m_fflags = 5'b0;
        m_rc     = 16'b0;
        #2;
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        check_all();

        // Retire counter wrap under full-rate streaming
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 70000 && m_rc != 16'hFFFF; i++) begin
            drive_rand();
            cycle();
            if (m_rc[9:0] == 10'd0) check_all();
        end
        check("retire_at_max", bus.retire_cnt, 16'hFFFF);
        check_all();
        drive_rand();
        cycle();
        check("retire_wrapped", bus.retire_cnt, 16'h0000);
        check_all();
        bus.in_valid = 1'b0;
        repeat (5) begin
            cycle();
            check_all();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fpadd_wb.md
# fpadd_wb

Writeback/retire stage directly downstream of the combinational `fpadd` datapath. It captures each `fpadd` result with its exception flags and destination tag into a small in-order FIFO. For single precision it NaN-boxes the result, which `fpadd` returns in `result[63:32]`. It presents retired entries to the register-file write port over a valid/ready handshake and maintains the sticky floating-point exception-flag register and a retire counter.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `TAGW`, default 5: destination-register tag width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: an `fpadd` result is present this cycle.
- `in_ready`  out  1: the stage accepts an entry.
- `result`  in  64: `fpadd` result bus.
- `Flags`  in  5: `fpadd` flags. [4] invalid, [3] div-by-zero, [2] overflow, [1] underflow, [0] inexact.
- `Denorm`  in  1: `fpadd` denormal-result indicator.
- `P`  in  2: precision of the operation. 2'b01 single, 2'b00 double, 2'b10/2'b11 reserved.
- `in_tag`  in  TAGW: destination register.
- `out_valid`  out  1: the head entry is valid.
- `out_ready`  in  1: the consumer accepts the head entry.
- `out_data`  out  64: packed result.
- `out_tag`  out  TAGW: destination of the head entry.
- `out_flags`  out  5: flags of the head entry.
- `out_denorm`  out  1: Denorm of the head entry.
- `fflags_we`  in  1: software write of the sticky flags.
- `fflags_wdata`  in  5: value for that write.
- `fflags`  out  5: sticky exception flags.
- `retire_cnt`  out  16: count of retired entries, wrapping.

## Operation
- Push: occurs when `in_valid && in_ready`. The stored entry is {packed data, `in_tag`, `Flags`, `Denorm`}.
- Packing when `P==2'b01`: data = {32'hFFFF_FFFF, `result[63:32]`}.
- Packing for any other `P`: data = `result` unchanged.
- `in_ready` = (count < DEPTH). It depends on the registered count only, with no combinational path from `out_ready`.
- Pop: occurs when `out_valid && out_ready`. Entries leave in strict FIFO order.
- `out_valid` = (count != 0). While the FIFO is empty, `out_data`, `out_tag`, `out_flags` and `out_denorm` are all zero.
- Count update:
  - count += push − pop.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Full FIFO: `in_ready`=0, even if a pop occurs in the same cycle. There is no pass-through of a push into a full FIFO.
- Empty FIFO: no bypass path; a pushed entry is never visible in the cycle it is pushed.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Sticky flags: next `fflags` = (`fflags_we` ? `fflags_wdata` : `fflags`) | (pop ? head `out_flags` : 5'b0). A popped entry's flags are therefore never lost to a simultaneous software write.
- `retire_cnt` increments by 1 on each pop and wraps from 16'hFFFF to 16'h0000.

## Timing
- Reset asserted, asynchronously: count=0, both pointers=0, `fflags`=0, `retire_cnt`=0, `out_valid`=0, all `out_*`=0. `in_ready` is forced to 0 while reset is low.
- Reset asserted mid-operation: all entries are discarded immediately. After release, `in_ready`=1 in the first cycle.
- Latency: an entry pushed at edge N drives `out_valid`=1 from just after edge N. It can pop at edge N+1 at the earliest.
- Throughput: one push and one pop per cycle in steady state.
- `fflags` and `retire_cnt` update at the pop edge and are visible in the following cycle.
- All outputs except `in_ready` during reset come from registers or from a FIFO-read mux indexed by a registered pointer.

## Test plan
- Single-precision pack: push `result`=64'h3F80_0000_0000_0000, `P`=01, tag 5'd3, `Flags`=5'b00001; → next cycle `out_data`=64'hFFFF_FFFF_3F80_0000, `out_tag`=3. After the pop: `fflags`=5'b00001, `retire_cnt`=1.
- Double passthrough: push 64'h4000_0000_0000_0000 with `P`=00 → `out_data` is identical to the input.
- Fill and backpressure: hold `out_ready`=0 and push 5 consecutive entries with DEPTH=4. → `in_ready` drops after the 4th push and the 5th is not accepted. Then assert `out_ready` for 4 cycles → tags pop in push order, then `out_valid`=0.
- Sticky collision: with `fflags`=5'b00100, assert `fflags_we` with `fflags_wdata`=0 in the same cycle as a pop carrying 5'b10000. → `fflags`=5'b10000.
- Reset mid-stream: with 3 entries queued, pulse `reset` low. → immediately `out_valid`=0 and `in_ready`=0; after release count=0, `fflags`=0, `in_ready`=1.
- Wrap: preset via 65535 pops of streaming traffic, then one more pop → `retire_cnt` goes from 16'hFFFF to 16'h0000. Pointer wrap is checked as correct FIFO order across ≥2·DEPTH entries.
